ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares the single-port 32x16 data RAM between NUM_REQ requesters.
//   Accepts one read/write command at a time via valid/ready, drives RAM write_enable/address/data_in.
//   Returns a one-cycle response pulse to the issuing requester; also sequences a whole-RAM clear via the RAM's sync reset.
//   Sits between the core's memory clients (fetch, load/store, debug) and the RAM instance.
// PARAMETERS
//   NUM_REQ     2   number of requesters (2..4)
//   ADDR_WIDTH  5   RAM address width (32 locations)
//   DATA_WIDTH  16  RAM word width
// PORTS
//   clock           in   1                     single clock, all state on posedge
//   reset           in   1                     asynchronous, active-high; clears all arbiter state
//   req_valid       in   NUM_REQ               per-requester command valid
//   req_ready       out  NUM_REQ               one-hot grant; handshake = valid & ready
//   req_write       in   NUM_REQ               1 = write, 0 = read
//   req_addr        in   NUM_REQ*ADDR_WIDTH    flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata       in   NUM_REQ*DATA_WIDTH    flattened write data, same slicing
//   resp_valid      out  NUM_REQ               one-cycle completion pulse to owning requester
//   resp_rdata      out  DATA_WIDTH            read data; 0 for write responses
//   clear_req       in   1                     request full-RAM clear (level)
//   clear_ack       out  1                     one-cycle pulse: clear performed at end of this cycle
//   ram_reset       out  1                     to RAM reset (synchronous clear inside RAM)
//   ram_write_enable out 1                     to RAM write_enable
//   ram_address     out  ADDR_WIDTH            to RAM address
//   ram_data_in     out  DATA_WIDTH            to RAM data_in
//   ram_data_out    in   DATA_WIDTH            from RAM data_out (registered in RAM, 1-cycle)
// BEHAVIOUR
//   - Reset values: state=IDLE, cmd regs (owner, write, addr, wdata)=0, last_grant=NUM_REQ-1.
//     All outputs 0 during and after reset until a request arrives.
//   - FSM: IDLE -> ISSUE -> RESP -> IDLE. CLEAR: IDLE -> CLEAR -> IDLE.
//   - IDLE: if clear_req=1 -> CLEAR; requests are not granted this cycle (clear wins).
//     Else pick the first valid requester scanning from last_grant+1 mod NUM_REQ upward.
//     Drive req_ready one-hot for it (combinational on req_valid); on the edge load cmd regs,
//     last_grant <= winner, -> ISSUE. No valid -> stay IDLE, req_ready=0.
//   - ISSUE: ram_address=cmd_addr, ram_data_in=cmd_wdata, ram_write_enable=cmd_write; -> RESP.
//   - RESP: resp_valid[cmd_owner]=1; resp_rdata = cmd_write ? 0 : ram_data_out; -> IDLE.
//   - CLEAR: ram_reset=1, clear_ack=1, ram_write_enable=0; -> IDLE. Requester drops clear_req after ack.
//   - Outside ISSUE: ram_write_enable=0. Outside CLEAR: ram_reset=0.
//     ram_address/ram_data_in always follow cmd regs (stable, no glitching).
//   - Latency: handshake at edge N -> RAM acts at edge N+1 -> resp_valid high in cycle N+1..N+2.
//     Throughput: one command per 3 cycles; req_ready=0 in ISSUE/RESP/CLEAR.
//   - Requesters hold valid, write, addr and wdata stable until handshake. Responses have no backpressure.
//   - Write then read of same address from any requester returns the new data (ops are serialised).
//   - Reset mid-operation (ISSUE/RESP/CLEAR): immediate return to IDLE.
//     The in-flight op gets no response; RAM contents are not touched by this reset.
//   - Unused requester slices ignored; NUM_REQ=1 degenerates to fixed grant.
// STRUCTURE
//   - ram_arb_pkg: state enum {IDLE, ISSUE, RESP, CLEAR} (2-bit), default width constants.
//   - Sub-module rr_priority_picker (combinational):
//     req vector + last_grant in -> one-hot grant + index out. FSM and cmd regs stay in top.
// TESTING
//   1. Reset asserted mid-ISSUE of a write -> state IDLE, resp_valid=0, ram_write_enable=0 same cycle.
//   2. Req0 write addr 3 = 16'hA5A5 then read addr 3 -> write resp_rdata=0; read resp_rdata=16'hA5A5
//      two cycles after handshake.
//   3. Both requesters hold valid reads (addr 1, addr 2) continuously:
//      grants alternate 0,1,0,1; each resp to correct owner.
//   4. Write addr 31 = 16'hFFFF, then addr 0 = 16'h0001, read both -> 16'hFFFF, 16'h0001 (no wrap aliasing).
//   5. clear_req raised together with req0 valid -> CLEAR first (ram_reset one cycle, clear_ack);
//      req0 granted next; read of any previously written address returns 16'h0000.
//   6. Req1 valid alone after reset -> granted; then req0 and req1 both valid -> req0 granted (pointer advanced).

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM state encoding,
// default geometry and small index helpers used by the picker and the top.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 16;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requester slot visited at a given scan step after the last grant.
  function automatic int rr_slot(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request scanning upward
// from the slot after last_grant, returned as one-hot and as an index.
module rr_priority_picker
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int   slot_s;
  logic hit_s;

  // Scan slots in rotating order; only the first hit is kept.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    hit_s     = 1'b0;
    slot_s    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      slot_s    = rr_slot(int'(last_grant), k, NUM_REQ);
      hit_s     = ~grant_any & (|(req & (NUM_REQ'(1'b1) << slot_s)));
      grant     = grant | ({NUM_REQ{hit_s}} & (NUM_REQ'(1'b1) << slot_s));
      grant_idx = hit_s ? IDX_W'(slot_s) : grant_idx;
      grant_any = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port data RAM between NUM_REQ requesters: round-robin
// grant, one command in flight, response pulse to the owner, and whole-RAM clear.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  input  logic                           clear_req,
  output logic                           clear_ack,
  output logic                           ram_reset,
  output logic                           ram_write_enable,
  output logic [ADDR_WIDTH-1:0]          ram_address,
  output logic [DATA_WIDTH-1:0]          ram_data_in,
  input  logic [DATA_WIDTH-1:0]          ram_data_out
);

  localparam int               IDX_W      = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e                state_r;
  arb_state_e                state_nxt_s;
  logic [IDX_W-1:0]          last_grant_r;
  logic [IDX_W-1:0]          cmd_owner_r;
  logic                      cmd_write_r;
  logic [ADDR_WIDTH-1:0]     cmd_addr_r;
  logic [DATA_WIDTH-1:0]     cmd_wdata_r;

  logic [NUM_REQ-1:0]        pick_grant_s;
  logic [IDX_W-1:0]          pick_idx_s;
  logic                      pick_any_s;
  logic                      load_s;
  logic                      sel_write_s;
  logic [ADDR_WIDTH-1:0]     sel_addr_s;
  logic [DATA_WIDTH-1:0]     sel_wdata_s;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .grant_idx  (pick_idx_s),
    .grant_any  (pick_any_s)
  );

  // One-hot mux of the winning requester's command fields.
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_write_s = sel_write_s | (pick_grant_s[i] & req_write[i]);
      sel_addr_s  = sel_addr_s  | ({ADDR_WIDTH{pick_grant_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_wdata_s = sel_wdata_s | ({DATA_WIDTH{pick_grant_s[i]}} & req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next-state logic; a pending clear takes precedence over any request.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_req) begin
          state_nxt_s = CLEAR;
        end else if (pick_any_s) begin
          state_nxt_s = ISSUE;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:   state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      CLEAR:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state outputs; grant is masked while reset is held so all outputs read 0.
  always_comb begin
    req_ready        = '0;
    resp_valid       = '0;
    resp_rdata       = '0;
    clear_ack        = 1'b0;
    ram_reset        = 1'b0;
    ram_write_enable = 1'b0;
    case (state_r)
      IDLE:  req_ready = (clear_req | reset) ? '0 : pick_grant_s;
      ISSUE: ram_write_enable = cmd_write_r;
      RESP: begin
        resp_valid = NUM_REQ'(1'b1) << cmd_owner_r;
        resp_rdata = cmd_write_r ? '0 : ram_data_out;
      end
      CLEAR: begin
        clear_ack = 1'b1;
        ram_reset = 1'b1;
      end
      default: req_ready = '0;
    endcase
  end

  assign ram_address = cmd_addr_r;
  assign ram_data_in = cmd_wdata_r;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command capture and round-robin pointer, updated on each handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_r <= LAST_RESET;
      cmd_owner_r  <= '0;
      cmd_write_r  <= 1'b0;
      cmd_addr_r   <= '0;
      cmd_wdata_r  <= '0;
    end else if (load_s) begin
      last_grant_r <= pick_idx_s;
      cmd_owner_r  <= pick_idx_s;
      cmd_write_r  <= sel_write_s;
      cmd_addr_r   <= sel_addr_s;
      cmd_wdata_r  <= sel_wdata_s;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, transaction-level
// reference model, directed scenarios followed by randomized traffic.
module tb_ram_port_arbiter;
  localparam int NUM_REQ = 2;
  localparam int AW      = 5;
  localparam int DW      = 16;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid, req_ready, req_write, resp_valid;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*DW-1:0]   req_wdata;
  logic [DW-1:0]           resp_rdata, ram_data_in;
  logic [DW-1:0]           ram_data_out = '0;
  logic                    clear_req, clear_ack, ram_reset, ram_write_enable;
  logic [AW-1:0]           ram_address;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .clear_req(clear_req), .clear_ack(clear_ack),
    .ram_reset(ram_reset), .ram_write_enable(ram_write_enable),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural 32x16 RAM: registered read, synchronous whole-array clear.
  logic [DW-1:0] ram_mem [0:31] = '{default: '0};
  always @(posedge clock) begin
    if (ram_reset) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= '0;
      ram_data_out <= '0;
    end else begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, pointer and the one command in flight.
  logic [DW-1:0]      m_mem [0:31] = '{default: '0};
  int                 m_phase, m_nxt, m_last, m_owner, m_win;
  logic               m_write;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [NUM_REQ-1:0] exp_ready, exp_resp;
  logic [DW-1:0]      exp_rdata;
  logic               exp_we, exp_clr;

  always @(negedge clock) begin
    if (reset) begin
      m_phase = 0; m_last = NUM_REQ - 1; m_owner = 0;
      m_write = 1'b0; m_addr = '0; m_wdata = '0;
      check("rst_ctrl", {req_ready, resp_valid, clear_ack, ram_reset, ram_write_enable}, 32'd0);
      check("rst_addr", ram_address, 32'd0);
      check("rst_din", ram_data_in, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
    end else begin
      exp_ready = '0; exp_resp = '0; exp_rdata = '0; exp_we = 1'b0; exp_clr = 1'b0;
      m_nxt = 0; m_win = 0;
      case (m_phase)
        0: begin
          if (clear_req) begin
            m_nxt = 3;
          end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
              if (req_valid[(m_last + k) % NUM_REQ] && exp_ready == '0) begin
                m_win = (m_last + k) % NUM_REQ;
                exp_ready[m_win] = 1'b1;
              end
            end
            m_nxt = (exp_ready != '0) ? 1 : 0;
          end
        end
        1: begin exp_we = m_write; m_nxt = 2; end
        2: begin
          exp_resp[m_owner] = 1'b1;
          exp_rdata = m_write ? '0 : m_mem[m_addr];
          m_nxt = 0;
        end
        3: begin exp_clr = 1'b1; m_nxt = 0; end
        default: m_nxt = 0;
      endcase
      check("ready", req_ready, exp_ready);
      check("resp_valid", resp_valid, exp_resp);
      check("resp_rdata", resp_rdata, exp_rdata);
      check("write_enable", ram_write_enable, exp_we);
      check("clear_ack_ram_reset", {clear_ack, ram_reset}, {exp_clr, exp_clr});
      check("ram_address", ram_address, m_addr);
      check("ram_data_in", ram_data_in, m_wdata);
      if (m_phase == 0 && m_nxt == 1) begin
        m_owner = m_win; m_last = m_win;
        m_write = req_write[m_win];
        m_addr  = req_addr[m_win*AW +: AW];
        m_wdata = req_wdata[m_win*DW +: DW];
      end
      if (m_phase == 1 && m_write) m_mem[m_addr] = m_wdata;
      if (m_phase == 3) for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_phase = m_nxt;
    end
  end

  task automatic set_req(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r] = 1'b1;
    req_write[r] = w;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  // Issue one command from requester r; call and return at posedge+1.
  task automatic do_cmd(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rdata, output int lat);
    int  n;
    bit  hs, got;
    set_req(r, w, a, d);
    n = 0; hs = 1'b0;
    while (!hs && n < 20) begin
      @(negedge clock);
      hs = req_ready[r];
      n++;
    end
    check("cmd_handshake", hs, 1);
    @(posedge clock); #1;
    req_valid[r] = 1'b0;
    n = 0; got = 1'b0; rdata = '0;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      if (resp_valid[r]) begin got = 1'b1; rdata = resp_rdata; end
    end
    lat = n;
    check("cmd_response", got, 1);
    @(posedge clock); #1;
  endtask

  initial begin #2000000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    logic [DW-1:0]      rd;
    int                 lat, n_grants, cyc, left0, left1;
    logic [NUM_REQ-1:0] g, hs_v;
    logic [NUM_REQ-1:0] grants [4];
    bit                 ack;

    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; clear_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Req1 alone after reset, then both hold reads: pointer advance and alternation.
    do_cmd(1, 1'b1, 5'd7, 16'h1234, rd, lat);
    check("t6_req1_write_rdata", rd, 32'd0);
    set_req(0, 1'b0, 5'd1, 16'h0000);
    set_req(1, 1'b0, 5'd2, 16'h0000);
    n_grants = 0; cyc = 0; left0 = 2; left1 = 2;
    while (n_grants < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      g = req_ready;
      if (g != '0) begin grants[n_grants] = g; n_grants++; end
      @(posedge clock); #1;
      if (g[0]) begin left0--; if (left0 == 0) req_valid[0] = 1'b0; end
      if (g[1]) begin left1--; if (left1 == 0) req_valid[1] = 1'b0; end
    end
    check("t3_grant_count", n_grants, 4);
    for (int k = 0; k < 4; k++)
      check("t3_grant_order", grants[k], (k % 2 == 0) ? 32'd1 : 32'd2);
    repeat (2) @(posedge clock);
    #1;

    // Write then read back, with latency from handshake to response.
    do_cmd(0, 1'b1, 5'd3, 16'hA5A5, rd, lat);
    check("t2_write_rdata", rd, 32'd0);
    do_cmd(0, 1'b0, 5'd3, 16'h0000, rd, lat);
    check("t2_read_rdata", rd, 32'hA5A5);
    check("t2_latency", lat, 32'd2);

    // Address extremes must not alias.
    do_cmd(0, 1'b1, 5'd31, 16'hFFFF, rd, lat);
    do_cmd(1, 1'b1, 5'd0, 16'h0001, rd, lat);
    do_cmd(1, 1'b0, 5'd31, 16'h0000, rd, lat);
    check("t4_read31", rd, 32'hFFFF);
    do_cmd(0, 1'b0, 5'd0, 16'h0000, rd, lat);
    check("t4_read0", rd, 32'h0001);

    // Reset while a write is in ISSUE: nothing reaches the RAM.
    set_req(0, 1'b1, 5'd9, 16'hBEEF);
    @(negedge clock);
    check("t1_grant", req_ready, 32'd1);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    check("t1_we_in_issue", ram_write_enable, 32'd1);
    reset = 1'b1;
    #1;
    check("t1_state_idle", dut.state_r, 32'd0);
    check("t1_we_dropped", ram_write_enable, 32'd0);
    check("t1_no_resp", resp_valid, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    do_cmd(0, 1'b0, 5'd9, 16'h0000, rd, lat);
    check("t1_addr9_untouched", rd, 32'd0);

    // Clear raised together with a request: clear first, then the request.
    do_cmd(0, 1'b1, 5'd5, 16'h1357, rd, lat);
    clear_req = 1'b1;
    set_req(0, 1'b0, 5'd5, 16'h0000);
    @(negedge clock);
    check("t5_no_grant", req_ready, 32'd0);
    @(negedge clock);
    check("t5_ack", {clear_ack, ram_reset}, 32'd3);
    @(posedge clock); #1;
    clear_req = 1'b0;
    @(negedge clock);
    check("t5_grant_after_clear", req_ready, 32'd1);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t5_resp_owner", resp_valid, 32'd1);
    check("t5_rdata_cleared", resp_rdata, 32'd0);
    @(posedge clock); #1;
    do_cmd(1, 1'b0, 5'd3, 16'h0000, rd, lat);
    check("t5_addr3_cleared", rd, 32'd0);
    do_cmd(0, 1'b0, 5'd31, 16'h0000, rd, lat);
    check("t5_addr31_cleared", rd, 32'd0);

    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      hs_v = req_valid & req_ready;
      ack  = clear_ack;
      @(posedge clock); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req_valid[r] || hs_v[r]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
          else
            req_valid[r] = 1'b0;
        end
      end
      if (ack) clear_req = 1'b0;
      else if (!clear_req && $urandom_range(0, 49) == 0) clear_req = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
